// File: rtl/frame_pkg.sv
// Shared types and constants for the frame timing monitor and its generator.
package frame_pkg;

  // IDLE wait for sof | SOF measure sof | BODY pri pulses | EOF measure eof
  typedef enum logic [1:0] {IDLE, SOF, BODY, EOF} state_e;

  localparam int ERR_SOF   = 0;
  localparam int ERR_PRIW  = 1;
  localparam int ERR_PRIP  = 2;
  localparam int ERR_EOF   = 3;
  localparam int ERR_CNT   = 4;
  localparam int ERR_TMO   = 5;
  localparam int ERR_RESOF = 6;
  localparam int ERR_W     = 7;

  localparam int DEF_SOF_LEN    = 4;
  localparam int DEF_PRI_HIGH   = 30;
  localparam int DEF_PRI_PERIOD = 100;
  localparam int DEF_PRI_COUNT  = 50;
  localparam int DEF_EOF_LEN    = 13;
  localparam int DEF_MAX_FRAME  = 8192;
  localparam int DEF_CW         = 16;

endpackage

// File: rtl/frame_edge_det.sv
// Registers a strobe and reports its level plus rise/fall against the previous sample.
module frame_edge_det (
  input  logic clk_i,
  input  logic reset_i,
  input  logic x_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic x_q;
  logic x_prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q      <= 1'b0;
      x_prev_q <= 1'b0;
    end else begin
      x_q      <= x_i;
      x_prev_q <= x_q;
    end
  end

  assign level_o = x_q;
  assign rise_o  = x_q & ~x_prev_q;
  assign fall_o  = ~x_q & x_prev_q;

endmodule

// File: rtl/frame_monitor.sv
// Measures sof/pri/eof timing of each frame and reports a sticky status word per frame.
module frame_monitor
  import frame_pkg::*;
#(
  parameter int SOF_LEN    = DEF_SOF_LEN,
  parameter int PRI_HIGH   = DEF_PRI_HIGH,
  parameter int PRI_PERIOD = DEF_PRI_PERIOD,
  parameter int PRI_COUNT  = DEF_PRI_COUNT,
  parameter int EOF_LEN    = DEF_EOF_LEN,
  parameter int MAX_FRAME  = DEF_MAX_FRAME,
  parameter int CW         = DEF_CW
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sof_i,
  input  logic              pri_i,
  input  logic              eof_i,
  output logic              frame_done_o,
  output logic              frame_ok_o,
  output logic [ERR_W-1:0]  frame_err_o,
  output logic [CW-1:0]     pri_count_o,
  output logic [31:0]       frame_len_o
);

  localparam logic [CW-1:0] SOF_LEN_C    = CW'(SOF_LEN);
  localparam logic [CW-1:0] PRI_HIGH_C   = CW'(PRI_HIGH);
  localparam logic [CW-1:0] PRI_PERIOD_C = CW'(PRI_PERIOD);
  localparam logic [CW-1:0] PRI_COUNT_C  = CW'(PRI_COUNT);
  localparam logic [CW-1:0] EOF_LEN_C    = CW'(EOF_LEN);
  localparam logic [31:0]   MAX_C        = 32'(MAX_FRAME);
  localparam logic [CW-1:0] ONE_C        = CW'(1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic sof_lvl, sof_rise, sof_fall;
  logic pri_lvl, pri_rise, pri_fall;
  logic eof_lvl, eof_rise, eof_fall;

  frame_edge_det u_sof (.clk_i(clk_i), .reset_i(reset_i), .x_i(sof_i),
                        .level_o(sof_lvl), .rise_o(sof_rise), .fall_o(sof_fall));
  frame_edge_det u_pri (.clk_i(clk_i), .reset_i(reset_i), .x_i(pri_i),
                        .level_o(pri_lvl), .rise_o(pri_rise), .fall_o(pri_fall));
  frame_edge_det u_eof (.clk_i(clk_i), .reset_i(reset_i), .x_i(eof_i),
                        .level_o(eof_lvl), .rise_o(eof_rise), .fall_o(eof_fall));

  state_e           state_q;
  logic [CW-1:0]    sof_w_q, pw_q, pper_q, eof_w_q, pcnt_q, pcnt_d;
  logic [31:0]      len_q, len_d;
  logic [ERR_W-1:0] err_q, err_d, err_set;
  logic             tmo, resof, report;

  logic             frame_done_q, frame_ok_q;
  logic [ERR_W-1:0] frame_err_q;
  logic [CW-1:0]    pri_count_q;
  logic [31:0]      frame_len_q;

  always_comb begin
    err_set = '0;
    len_d   = (&len_q) ? len_q : len_q + 32'd1;
    tmo     = (state_q != IDLE) && (len_d >= MAX_C);
    resof   = ((state_q == BODY) || (state_q == EOF)) && sof_rise;
    pcnt_d  = ((state_q == BODY) && pri_rise) ? sat_inc(pcnt_q) : pcnt_q;
    case (state_q)
      SOF: if (sof_fall && (sof_w_q != SOF_LEN_C)) err_set[ERR_SOF] = 1'b1;
      BODY: begin
        // The first rise has no predecessor, so its period is not checked.
        if (pri_rise && (pcnt_q != '0) && (pper_q != PRI_PERIOD_C)) err_set[ERR_PRIP] = 1'b1;
        if (pri_fall && (pw_q != PRI_HIGH_C)) err_set[ERR_PRIW] = 1'b1;
        if (eof_rise && pri_lvl) err_set[ERR_PRIW] = 1'b1;
      end
      EOF: if (eof_fall) begin
        if (eof_w_q != EOF_LEN_C) err_set[ERR_EOF] = 1'b1;
        if (pcnt_q != PRI_COUNT_C) err_set[ERR_CNT] = 1'b1;
      end
      default: ;
    endcase
    if (resof) err_set[ERR_RESOF] = 1'b1;
    if (tmo)   err_set[ERR_TMO]   = 1'b1;
    err_d  = err_q | err_set;
    report = resof || tmo || ((state_q == EOF) && eof_fall);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      sof_w_q      <= '0;
      pw_q         <= '0;
      pper_q       <= '0;
      eof_w_q      <= '0;
      pcnt_q       <= '0;
      len_q        <= '0;
      err_q        <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= '0;
      pri_count_q  <= '0;
      frame_len_q  <= '0;
    end else begin
      frame_done_q <= report;
      err_q        <= err_d;
      pcnt_q       <= pcnt_d;
      if (report) begin
        frame_err_q <= err_d;
        frame_ok_q  <= (err_d == '0);
        pri_count_q <= pcnt_d;
        frame_len_q <= len_d;
      end
      if (state_q != IDLE) len_q <= len_d;
      case (state_q)
        IDLE: begin
          sof_w_q <= '0;
          pw_q    <= '0;
          pper_q  <= '0;
          eof_w_q <= '0;
          pcnt_q  <= '0;
          err_q   <= '0;
          len_q   <= '0;
          if (sof_rise) begin
            state_q <= SOF;
            sof_w_q <= ONE_C;
            len_q   <= 32'd1;
          end
        end
        SOF: begin
          if (sof_fall) state_q <= BODY;
          else if (sof_lvl) sof_w_q <= sat_inc(sof_w_q);
        end
        BODY: begin
          pper_q <= pri_rise ? ONE_C : sat_inc(pper_q);
          if (pri_rise) pw_q <= ONE_C;
          else if (pri_lvl) pw_q <= sat_inc(pw_q);
          if (eof_rise) begin
            state_q <= EOF;
            eof_w_q <= ONE_C;
          end
        end
        EOF: begin
          if (eof_lvl) eof_w_q <= sat_inc(eof_w_q);
          if (eof_fall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // An sof rise inside a frame restarts measurement on the same edge it reports.
      if (resof) begin
        state_q <= SOF;
        sof_w_q <= ONE_C;
        len_q   <= 32'd1;
        err_q   <= '0;
        pcnt_q  <= '0;
        pw_q    <= '0;
        pper_q  <= '0;
        eof_w_q <= '0;
      end else if (tmo) begin
        state_q <= IDLE;
      end
    end
  end

  assign frame_done_o = frame_done_q;
  assign frame_ok_o   = frame_ok_q;
  assign frame_err_o  = frame_err_q;
  assign pri_count_o  = pri_count_q;
  assign frame_len_o  = frame_len_q;

endmodule

// File: tb/tb_frame_monitor.sv
// Directed bench for frame_monitor: nominal, error, timeout, abort and reset frames.
module tb_frame_monitor;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        sof_i, pri_i, eof_i;
  logic        frame_done_o, frame_ok_o;
  logic [6:0]  frame_err_o;
  logic [15:0] pri_count_o;
  logic [31:0] frame_len_o;

  frame_monitor dut (
    .clk_i(clk_i), .reset_i(reset_i), .sof_i(sof_i), .pri_i(pri_i), .eof_i(eof_i),
    .frame_done_o(frame_done_o), .frame_ok_o(frame_ok_o), .frame_err_o(frame_err_o),
    .pri_count_o(pri_count_o), .frame_len_o(frame_len_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [6:0]  err;
    logic        ok;
    logic [15:0] cnt;
    logic [31:0] len;
    int          cyc;
  } rep_t;

  rep_t rq[$];
  rep_t mon_r;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   dbl_cnt = 0;
  logic done_prev = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (frame_done_o) begin
      mon_r.err = frame_err_o;
      mon_r.ok  = frame_ok_o;
      mon_r.cnt = pri_count_o;
      mon_r.len = frame_len_o;
      mon_r.cyc = cyc;
      rq.push_back(mon_r);
      if (done_prev) dbl_cnt++;
    end
    done_prev = frame_done_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic p, input logic e);
    sof_i = s; pri_i = p; eof_i = e;
    @(posedge clk_i);
    #1;
  endtask

  // eof_len == 0 leaves the frame open (no eof, no trailing idle).
  task automatic frame(input int sof_len, input int npulse, input int bad_hi_idx, input int bad_hi,
                       input int bad_per_idx, input int bad_per, input int eof_len,
                       output int flen, output int sof_cyc, output int efall_cyc);
    int h, per;
    sof_cyc = cyc;
    repeat (sof_len) step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < npulse; k++) begin
      h   = (k == bad_hi_idx) ? bad_hi : 30;
      per = (k == bad_per_idx) ? bad_per : 100;
      repeat (h) step(1'b0, 1'b1, 1'b0);
      repeat (per - h) step(1'b0, 1'b0, 1'b0);
    end
    if (eof_len > 0) begin
      repeat (eof_len) step(1'b0, 1'b0, 1'b1);
      efall_cyc = cyc;
      flen = efall_cyc - sof_cyc + 1;
      repeat (6) step(1'b0, 1'b0, 1'b0);
    end else begin
      efall_cyc = cyc;
      flen = cyc - sof_cyc + 1;
    end
  endtask

  task automatic expect_rep(input string tag, input logic [6:0] err, input int cnt, input int len,
                            output int dcyc);
    rep_t r;
    dcyc = -1;
    check({tag, "_present"}, 32'(rq.size() != 0), 32'd1);
    if (rq.size() != 0) begin
      r = rq.pop_front();
      dcyc = r.cyc;
      check({tag, "_err"}, {25'd0, r.err}, {25'd0, err});
      check({tag, "_ok"},  {31'd0, r.ok},  {31'd0, (err == 7'd0)});
      check({tag, "_cnt"}, {16'd0, r.cnt}, 32'(cnt));
      check({tag, "_len"}, r.len, 32'(len));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"}, {31'd0, frame_done_o}, 32'd0);
    check({tag, "_ok"},   {31'd0, frame_ok_o},   32'd0);
    check({tag, "_err"},  {25'd0, frame_err_o},  32'd0);
    check({tag, "_cnt"},  {16'd0, pri_count_o},  32'd0);
    check({tag, "_len"},  frame_len_o,           32'd0);
  endtask

  initial begin
    int flen, flen_a, sof_cyc, efall, dcyc;

    reset_i = 1'b1; sof_i = 1'b0; pri_i = 1'b0; eof_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_outputs_zero("rst");
    reset_i = 1'b0;
    repeat (5) step(1'b0, 1'b0, 1'b0);

    // pri/eof strobes with no frame open must not produce a report
    repeat (30) step(1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    repeat (13) step(1'b0, 1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    check("idle_ignore", 32'(rq.size()), 32'd0);

    frame(4, 50, -1, 30, -1, 100, 13, flen, sof_cyc, efall);
    expect_rep("nom", 7'b0000000, 50, flen, dcyc);
    check("nom_flen", 32'(flen), 32'd5028);
    check("nom_latency", 32'(dcyc - efall), 32'd2);

    frame(5, 50, 7, 29, -1, 100, 13, flen, sof_cyc, efall);
    expect_rep("sofw_priw", 7'b0000011, 50, flen, dcyc);

    frame(4, 49, -1, 30, 9, 101, 12, flen, sof_cyc, efall);
    expect_rep("per_eof_cnt", 7'b0011100, 49, flen, dcyc);

    sof_cyc = cyc;
    repeat (4) step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    repeat (85) begin
      repeat (30) step(1'b0, 1'b1, 1'b0);
      repeat (70) step(1'b0, 1'b0, 1'b0);
    end
    repeat (20) step(1'b0, 1'b0, 1'b0);
    expect_rep("tmo", 7'b0100000, 82, 8192, dcyc);
    check("tmo_latency", 32'(dcyc - sof_cyc), 32'd8193);
    check("tmo_single", 32'(rq.size()), 32'd0);

    frame(4, 20, -1, 30, -1, 100, 0, flen_a, sof_cyc, efall);
    frame(4, 50, -1, 30, -1, 100, 13, flen, sof_cyc, efall);
    expect_rep("abort", 7'b1000000, 20, flen_a, dcyc);
    check("abort_flen", 32'(flen_a), 32'd2015);
    expect_rep("after_abort", 7'b0000000, 50, flen, dcyc);

    repeat (4) step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    repeat (10) begin
      repeat (30) step(1'b0, 1'b1, 1'b0);
      repeat (70) step(1'b0, 1'b0, 1'b0);
    end
    reset_i = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    reset_i = 1'b0;
    check_outputs_zero("midrst");
    repeat (200) step(1'b0, 1'b0, 1'b0);
    check("midrst_nodone", 32'(rq.size()), 32'd0);
    frame(4, 50, -1, 30, -1, 100, 13, flen, sof_cyc, efall);
    expect_rep("post_rst", 7'b0000000, 50, flen, dcyc);

    check("no_double_done", 32'(dbl_cnt), 32'd0);
    check("no_extra_reports", 32'(rq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_monitor.md
# frame_monitor

Timing checker that sits directly downstream of the frame generator and consumes its `sof`, `pri` and `eof` strobes. It measures each frame's SOF width, PRI pulse widths and periods, pulse count, EOF width and total length. It reports a per-frame status word with a one-cycle `frame_done` strobe, for use in self-checking benches and as an on-chip health monitor.

## Interface
- `SOF_LEN`, 4, expected SOF high width (cycles)
- `PRI_HIGH`, 30, expected PRI high width (cycles)
- `PRI_PERIOD`, 100, expected rise-to-rise PRI period (cycles)
- `PRI_COUNT`, 50, expected PRI pulses per frame
- `EOF_LEN`, 13, expected EOF high width (cycles)
- `MAX_FRAME`, 8192, frame timeout (cycles from SOF rise)
- `CW`, 16, width of internal counters and of `pri_count`
- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `sof`  in  1  start-of-frame strobe
- `pri`  in  1  pulse-repetition strobe
- `eof`  in  1  end-of-frame strobe
- `frame_done`  out  1  one-cycle strobe: frame status updated
- `frame_ok`  out  1  last reported frame had `frame_err == 0`
- `frame_err`  out  7  sticky error bits of the last reported frame
- `pri_count`  out  CW  PRI rising edges counted in the last frame
- `frame_len`  out  32  cycles from SOF rise to EOF fall (inclusive) of the last frame

## Operation
- Inputs are registered once into `*_q`. Rise = `x & ~x_q`. Fall = `~x & x_q`.
- States: IDLE, SOF, BODY, EOF.
- IDLE:
  - On `sof` rise, go to SOF.
  - Clear the working counters and working error bits.
  - Set `sof_w = 1` and `len = 1`.
- SOF:
  - While `sof` is high, increment `sof_w`.
  - On `sof` fall, go to BODY. If `sof_w != SOF_LEN`, set err[0].
- BODY:
  - On `pri` rise, increment `pcnt`.
  - On each `pri` rise except the first, check the rise-to-rise period. If it is not `PRI_PERIOD`, set err[2].
  - On `pri` fall, check the high width. If it is not `PRI_HIGH`, set err[1].
  - On `eof` rise, go to EOF with `eof_w = 1`. If `pri` is high at that point, set err[1] (truncated pulse).
- EOF:
  - Increment `eof_w` while `eof` is high.
  - On `eof` fall:
    - If `eof_w != EOF_LEN`, set err[3].
    - If `pcnt != PRI_COUNT`, set err[4].
    - Report the frame and go to IDLE.
- `len` increments every cycle in SOF, BODY and EOF.
- Timeout: if `len` reaches `MAX_FRAME` in any non-IDLE state, set err[5], report, and go to IDLE.
- Unexpected SOF: an `sof` rise in BODY or EOF sets err[6] and reports the aborted frame. In the same cycle, start a new frame in SOF with fresh counters (`sof_w = 1`, `len = 1`).
- `eof` or `pri` activity in IDLE is ignored.
- Report means, on the same edge:
  - Pulse `frame_done`.
  - Load `frame_err`, `pri_count` and `frame_len`.
  - Set `frame_ok = (err == 0)`.
- Reported outputs hold until the next report.
- Arithmetic:
  - All width and period counters saturate at `2^CW-1` and never wrap.
  - `len` is 32 bits and saturates.
  - A saturated value never equals a smaller expected value, so the error still fires.

## Timing
- On reset, all outputs and internal registers are 0, `*_q` are 0, and the state is IDLE.
- Reset mid-frame discards the frame. No `frame_done` is produced.
- Latency: an input changes before edge N and `*_q` captures it at edge N. The edge is detected between N and N+1, and `frame_done` is high for exactly the cycle after edge N+1.
- If timeout and `eof` fall occur in the same cycle, the `eof` fall is processed and err[5] is also set. The frame is reported once.
- `frame_done` never asserts on two consecutive cycles except when an unexpected SOF aborts a frame that then times out immediately. That case is impossible with `MAX_FRAME > 1`.

## Structure
- Package `frame_pkg` holds:
  - the state enum (IDLE, SOF, BODY, EOF);
  - error bit index constants: `ERR_SOF=0`, `ERR_PRIW=1`, `ERR_PRIP=2`, `ERR_EOF=3`, `ERR_CNT=4`, `ERR_TMO=5`, `ERR_RESOF=6`;
  - default timing constants shared with the generator.
- Sub-module `frame_edge_det` (registered rise/fall detector, 1 bit, sync reset), instantiated three times.

## Test plan
- Nominal frame: SOF 4 cycles, 50 PRI pulses (30 high, period 100), EOF 13 cycles → one `frame_done`, `frame_err = 0`, `frame_ok = 1`, `pri_count = 50`, `frame_len` equal to the cycle count from SOF rise to EOF fall.
- SOF 5 cycles and a PRI pulse 29 high, otherwise nominal → `frame_err = 7'b0000011`, `frame_ok = 0`.
- 49 pulses with the 10th period = 101, then EOF 12 cycles → `frame_err = 7'b0011100`, `pri_count = 49`.
- SOF then PRI pulses with no EOF, `MAX_FRAME = 8192` → `frame_done` on cycle 8192 after SOF rise, err[5] set.
- Second `sof` rise mid-BODY → aborted frame reported with err[6]. The following nominal frame reports `frame_err = 0`.
- `reset` asserted mid-BODY for 1 cycle, then a nominal frame → no `frame_done` for the aborted frame, all outputs 0 after reset, and the next frame reports OK.
